// File: rtl/key_debounce.sv
// key_debounce: four independent push-button debouncers.
// Each active-low key pin is synchronised, then qualified by a per-key FSM
// that requires CNT_MAX+1 consecutive stable synchronised samples before it
// accepts a press or a release.
// Ports:
//   clk         - system clock, rising edge
//   n_reset     - asynchronous active-low reset
//   key_n[3:0]  - raw, bouncing, active-low key pins (asynchronous to clk)
//   key_state   - debounced level per key, 1 = held (registered)
//   key_press   - one-cycle pulse per key on a debounced press (registered)
//   key_release - one-cycle pulse per key on a debounced release (registered)
module key_debounce #(
    parameter int unsigned CNT_MAX = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] key_n,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release
);

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned CNT_W    = 32;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 32'd1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [1:0]          r_state     [NUM_KEYS];
    logic [1:0]          w_state_nxt [NUM_KEYS];
    logic [CNT_W-1:0]    r_cnt       [NUM_KEYS];
    logic [CNT_W-1:0]    w_cnt_nxt   [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_key_state;
    logic [NUM_KEYS-1:0] w_key_state_nxt;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] w_press_nxt;
    logic [NUM_KEYS-1:0] r_release;
    logic [NUM_KEYS-1:0] w_release_nxt;

    // Two-flop synchroniser; resets to "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // State, counter and output registers for all keys.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_key_state <= '0;
            r_press     <= '0;
            r_release   <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_key_state <= w_key_state_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
        end
    end

    // Per-key next-state logic; pulses are decided here and registered above.
    always_comb begin
        w_key_state_nxt = r_key_state;
        w_press_nxt     = '0;
        w_release_nxt   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                S_IDLE: begin
                    w_cnt_nxt[i] = '0;
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = S_PRESS_WAIT;
                    end
                end
                S_PRESS_WAIT: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i]     = S_PRESSED;
                        w_cnt_nxt[i]       = '0;
                        w_key_state_nxt[i] = 1'b1;
                        w_press_nxt[i]     = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    w_cnt_nxt[i] = '0;
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = S_PRESSED;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i]     = S_IDLE;
                        w_cnt_nxt[i]       = '0;
                        w_key_state_nxt[i] = 1'b0;
                        w_release_nxt[i]   = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    assign key_state   = r_key_state;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce (CNT_MAX = 8).
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same
// point, so "tick n" after a drive corresponds to just after edge k+n-1,
// where edge k is the first edge that samples the new key_n value.
module tb_key_debounce;

    localparam int unsigned CNT_MAX = 8;
    localparam int          HIT     = CNT_MAX + 3;  // tick just after edge k+CNT_MAX+2

    logic       clk;
    logic       n_reset;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int checks = 0;
    int errors = 0;

    key_debounce #(.CNT_MAX(CNT_MAX)) u_dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles; press/release expected only at tick 'hit' (0 = never),
    // key_state switches from st_before to st_after at that tick.
    task automatic observe(input string tag, input int n, input int hit,
                           input logic [3:0] p_exp, input logic [3:0] r_exp,
                           input logic [3:0] st_before, input logic [3:0] st_after);
        for (int t = 1; t <= n; t++) begin
            tick();
            check({tag, ".press"},   32'(key_press),   32'((t == hit) ? p_exp : 4'h0));
            check({tag, ".release"}, 32'(key_release), 32'((t == hit) ? r_exp : 4'h0));
            check({tag, ".state"},   32'(key_state),
                  32'((hit != 0 && t >= hit) ? st_after : st_before));
        end
    endtask

    initial begin
        n_reset = 1'b0;
        key_n   = 4'hF;
        #3;
        check("rst_async.state",   32'(key_state),   32'h0);
        check("rst_async.press",   32'(key_press),   32'h0);
        check("rst_async.release", 32'(key_release), 32'h0);
        observe("rst_hold", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        n_reset = 1'b1;
        observe("idle", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Single key press, then release with identical latency.
        key_n = 4'b1110;
        observe("press0", 14, HIT, 4'b0001, 4'h0, 4'h0, 4'b0001);
        key_n = 4'b1111;
        observe("release0", 14, HIT, 4'h0, 4'b0001, 4'b0001, 4'h0);

        // Short release glitch from the held state is rejected.
        key_n = 4'b1110;
        observe("repress0", 14, HIT, 4'b0001, 4'h0, 4'h0, 4'b0001);
        key_n = 4'b1111;
        observe("glitch0_hi", 3, 0, 4'h0, 4'h0, 4'b0001, 4'b0001);
        key_n = 4'b1110;
        observe("glitch0_lo", 20, 0, 4'h0, 4'h0, 4'b0001, 4'b0001);
        key_n = 4'b1111;
        observe("release0b", 14, HIT, 4'h0, 4'b0001, 4'b0001, 4'h0);

        // Bouncy press on key 1: short burst rejected, final low qualifies.
        key_n = 4'b1101;
        observe("bounce1_lo", 5, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        key_n = 4'b1111;
        observe("bounce1_hi", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        key_n = 4'b1101;
        observe("press1", 20, HIT, 4'b0010, 4'h0, 4'h0, 4'b0010);
        key_n = 4'b1111;
        observe("release1", 14, HIT, 4'h0, 4'b0010, 4'b0010, 4'h0);

        // All keys on the same edge.
        key_n = 4'b0000;
        observe("press_all", 14, HIT, 4'hF, 4'h0, 4'h0, 4'hF);
        key_n = 4'b1111;
        observe("release_all", 14, HIT, 4'h0, 4'hF, 4'hF, 4'h0);

        // Reset while key 2 is held, then re-qualification after reset.
        key_n = 4'b1011;
        observe("press2", 14, HIT, 4'b0100, 4'h0, 4'h0, 4'b0100);
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_mid.state",   32'(key_state),   32'h0);
        check("rst_mid.press",   32'(key_press),   32'h0);
        check("rst_mid.release", 32'(key_release), 32'h0);
        observe("rst_mid_hold", 2, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        n_reset = 1'b1;
        observe("repress2", 14, HIT, 4'b0100, 4'h0, 4'h0, 4'b0100);
        key_n = 4'b1111;
        observe("release2", 14, HIT, 4'h0, 4'b0100, 4'b0100, 4'h0);

        // Key 3 toggling every cycle never qualifies.
        for (int c = 0; c < 100; c++) begin
            key_n = {~key_n[3], 3'b111};
            observe("toggle3", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
